// File: rtl/id_ex_decode_stage_if.sv
// ID/EX output bus: the decoded instruction as seen by the EX stage.
// The decode stage drives it through the master modport and the EX stage
// reads it through the slave modport.
//   ex_valid       EX slot holds a real instruction
//   ex_alu_op      4-bit ALU operation code (0000..1011)
//   ex_input_a/b   ALU operands
//   ex_store_data  rt value for sw
//   ex_wr_reg      destination register
//   ex_reg_write   register write enable
//   ex_mem_read    lw
//   ex_mem_write   sw
//   ex_branch      01 = beq, 10 = bne
//   ex_jump        01 = j/jal, 10 = jr
//   ex_set_lt      EX replaces the result with the SUB sign bit
//   ex_illegal     undecodable instruction
interface id_ex_decode_stage_if;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_input_a;
  logic [31:0] ex_input_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_branch;
  logic [1:0]  ex_jump;
  logic        ex_set_lt;
  logic        ex_illegal;

  modport master (
    output ex_valid, ex_alu_op, ex_input_a, ex_input_b, ex_store_data,
           ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_jump, ex_set_lt, ex_illegal
  );

  modport slave (
    input  ex_valid, ex_alu_op, ex_input_a, ex_input_b, ex_store_data,
           ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_jump, ex_set_lt, ex_illegal
  );
endinterface

// File: rtl/id_ex_decode_stage.sv
// Decode stage and ID/EX pipeline register of the 5-stage MIPS core.
// Decodes the IF/ID instruction into ALU op code, operands and control
// flags, and registers them for EX with one cycle of latency.
// Update priority on each edge: flush (bubble) > stall (hold) > load.
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset, clears every output
//   id_valid     id_instr holds a real instruction
//   id_instr     instruction word
//   id_pc_plus4  PC+4 of id_instr
//   id_rs_data   forwarded rs value
//   id_rt_data   forwarded rt value
//   stall        hold the ID/EX register
//   flush        load a bubble
//   ex           ID/EX output bus (master side)
module id_ex_decode_stage #(
  parameter int LINK_REG = 31
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [31:0]                 id_instr,
  input  logic [31:0]                 id_pc_plus4,
  input  logic [31:0]                 id_rs_data,
  input  logic [31:0]                 id_rt_data,
  input  logic                        stall,
  input  logic                        flush,
  id_ex_decode_stage_if.master        ex
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] store_data;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  branch;
    logic [1:0]  jump;
    logic        set_lt;
    logic        illegal;
  } dec_t;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  logic [5:0]  opcode_p0;
  logic [4:0]  rs_p0;
  logic [4:0]  rt_p0;
  logic [4:0]  rd_p0;
  logic [4:0]  shamt_p0;
  logic [5:0]  funct_p0;
  logic [15:0] imm_p0;
  logic signed [31:0] imm_sext_p0;
  logic [31:0] imm_zext_p0;

  logic        vld_p0;
  dec_t        dec_p0;
  logic        vld_p1;
  dec_t        dec_p1;

  // ---- stage p0: combinational decode of the IF/ID instruction ----
  assign opcode_p0   = id_instr[31:26];
  assign rs_p0       = id_instr[25:21];
  assign rt_p0       = id_instr[20:16];
  assign rd_p0       = id_instr[15:11];
  assign shamt_p0    = id_instr[10:6];
  assign funct_p0    = id_instr[5:0];
  assign imm_p0      = id_instr[15:0];
  assign imm_sext_p0 = sext16(imm_p0);
  assign imm_zext_p0 = zext16(imm_p0);

  // rs field is only needed for its value; the index itself is unused.
  logic unused_rs_p0;
  assign unused_rs_p0 = ^rs_p0;

  always_comb begin
    dec_p0 = '0;
    vld_p0 = id_valid;
    if (id_valid) begin
      case (opcode_p0)
        OP_RTYPE: begin
          case (funct_p0)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
              dec_p0.input_a   = id_rs_data;
              dec_p0.input_b   = id_rt_data;
              dec_p0.wr_reg    = rd_p0;
              dec_p0.reg_write = 1'b1;
              case (funct_p0)
                FN_ADD:  dec_p0.alu_op = ALU_ADD;
                FN_ADDU: dec_p0.alu_op = ALU_ADDU;
                FN_SUB:  dec_p0.alu_op = ALU_SUB;
                FN_SUBU: dec_p0.alu_op = ALU_SUBU;
                FN_AND:  dec_p0.alu_op = ALU_AND;
                FN_OR:   dec_p0.alu_op = ALU_OR;
                FN_XOR:  dec_p0.alu_op = ALU_XOR;
                FN_NOR:  dec_p0.alu_op = ALU_NOR;
                default: begin
                  // slt runs as SUB; EX keeps only the sign bit
                  dec_p0.alu_op = ALU_SUB;
                  dec_p0.set_lt = 1'b1;
                end
              endcase
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              // shift amount travels on A, the value to shift on B
              dec_p0.input_a   = {27'd0, shamt_p0};
              dec_p0.input_b   = id_rt_data;
              dec_p0.wr_reg    = rd_p0;
              dec_p0.reg_write = 1'b1;
              case (funct_p0)
                FN_SLL:  dec_p0.alu_op = ALU_SLL;
                FN_SRL:  dec_p0.alu_op = ALU_SRL;
                default: dec_p0.alu_op = ALU_SRA;
              endcase
            end
            FN_JR: begin
              dec_p0.input_a = id_rs_data;
              dec_p0.jump    = 2'b10;
            end
            default: begin
              dec_p0.alu_op  = ALU_ADDU;
              dec_p0.illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec_p0.input_a   = id_rs_data;
          dec_p0.wr_reg    = rt_p0;
          dec_p0.reg_write = 1'b1;
          case (opcode_p0)
            OP_ADDI:  begin dec_p0.alu_op = ALU_ADD;  dec_p0.input_b = imm_sext_p0; end
            OP_ADDIU: begin dec_p0.alu_op = ALU_ADDU; dec_p0.input_b = imm_sext_p0; end
            OP_SLTI:  begin
              dec_p0.alu_op  = ALU_SUB;
              dec_p0.input_b = imm_sext_p0;
              dec_p0.set_lt  = 1'b1;
            end
            OP_ANDI:  begin dec_p0.alu_op = ALU_AND;  dec_p0.input_b = imm_zext_p0; end
            OP_ORI:   begin dec_p0.alu_op = ALU_OR;   dec_p0.input_b = imm_zext_p0; end
            OP_XORI:  begin dec_p0.alu_op = ALU_XOR;  dec_p0.input_b = imm_zext_p0; end
            default:  begin dec_p0.alu_op = ALU_LUI;  dec_p0.input_b = imm_zext_p0; end
          endcase
        end
        OP_LW: begin
          dec_p0.alu_op    = ALU_ADD;
          dec_p0.input_a   = id_rs_data;
          dec_p0.input_b   = imm_sext_p0;
          dec_p0.wr_reg    = rt_p0;
          dec_p0.reg_write = 1'b1;
          dec_p0.mem_read  = 1'b1;
        end
        OP_SW: begin
          dec_p0.alu_op     = ALU_ADD;
          dec_p0.input_a    = id_rs_data;
          dec_p0.input_b    = imm_sext_p0;
          dec_p0.store_data = id_rt_data;
          dec_p0.mem_write  = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          // compare by subtraction; EX tests the zero flag
          dec_p0.alu_op  = ALU_SUBU;
          dec_p0.input_a = id_rs_data;
          dec_p0.input_b = id_rt_data;
          dec_p0.branch  = (opcode_p0 == OP_BEQ) ? 2'b01 : 2'b10;
        end
        OP_J: begin
          dec_p0.jump = 2'b01;
        end
        OP_JAL: begin
          // link value is computed as pc_plus4 + 0 through the ALU
          dec_p0.alu_op    = ALU_ADDU;
          dec_p0.input_a   = id_pc_plus4;
          dec_p0.wr_reg    = 5'(LINK_REG);
          dec_p0.reg_write = 1'b1;
          dec_p0.jump      = 2'b01;
        end
        default: begin
          dec_p0.alu_op  = ALU_ADDU;
          dec_p0.illegal = 1'b1;
        end
      endcase
      // $zero is never written
      if (dec_p0.wr_reg == 5'd0) dec_p0.reg_write = 1'b0;
    end
  end

  // ---- stage p1: ID/EX register (flush > stall > load) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      dec_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      dec_p1 <= '0;
    end else if (!stall) begin
      vld_p1 <= vld_p0;
      dec_p1 <= dec_p0;
    end
  end

  assign ex.ex_valid      = vld_p1;
  assign ex.ex_alu_op     = dec_p1.alu_op;
  assign ex.ex_input_a    = dec_p1.input_a;
  assign ex.ex_input_b    = dec_p1.input_b;
  assign ex.ex_store_data = dec_p1.store_data;
  assign ex.ex_wr_reg     = dec_p1.wr_reg;
  assign ex.ex_reg_write  = dec_p1.reg_write;
  assign ex.ex_mem_read   = dec_p1.mem_read;
  assign ex.ex_mem_write  = dec_p1.mem_write;
  assign ex.ex_branch     = dec_p1.branch;
  assign ex.ex_jump       = dec_p1.jump;
  assign ex.ex_set_lt     = dec_p1.set_lt;
  assign ex.ex_illegal    = dec_p1.illegal;

endmodule
